// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - single-frame VGA receiver writing the active area into a frame-buffer port
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int ADDR_W   = 19
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              p_tick,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [11:0]       rgb,
  input  logic              start,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_done,
  output logic              sync_err
);

  localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int PW = $clog2(H_BP + 1);
  localparam int LW = $clog2(V_BP + 1);

  localparam logic [CW-1:0] COL_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(V_ACTIVE - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(H_BP);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_BP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_VBP, S_HBP, S_ACTIVE, S_HWAIT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              hs_prev_q, vs_prev_q;
  logic [LW-1:0]     line_q, line_d;
  logic [PW-1:0]     pix_q, pix_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [11:0]       wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              take_px;

  // Sync levels are normalised to "asserted"; edges exist only on p_tick samples.
  logic hs_now, hs_was, vs_now, vs_was;
  logic hs_trail, hs_lead, vs_trail, vs_lead;
  assign hs_now   = (hsync == SYNC_POL);
  assign hs_was   = (hs_prev_q == SYNC_POL);
  assign vs_now   = (vsync == SYNC_POL);
  assign vs_was   = (vs_prev_q == SYNC_POL);
  assign hs_trail = p_tick &  hs_was & ~hs_now;
  assign hs_lead  = p_tick & ~hs_was &  hs_now;
  assign vs_trail = p_tick &  vs_was & ~vs_now;
  assign vs_lead  = p_tick & ~vs_was &  vs_now;

  assign busy       = busy_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = done_q;
  assign sync_err   = err_q;

  // State, counters, registered outputs and the previous-sample sync levels.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      hs_prev_q <= ~SYNC_POL;
      vs_prev_q <= ~SYNC_POL;
      line_q    <= '0;
      pix_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      pix_q     <= pix_d;
      col_q     <= col_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      if (p_tick) begin
        hs_prev_q <= hsync;
        vs_prev_q <= vsync;
      end
    end
  end

  // Next-state and next-output decode; a pixel is taken either as the last
  // back-porch tick (column 0) or as any clean tick while ACTIVE.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    pix_d     = pix_q;
    col_d     = col_q;
    row_d     = row_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = err_q;
    take_px   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARM;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      S_ARM: begin
        if (vs_trail) begin
          state_d = S_VBP;
          line_d  = '0;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
        end
      end
      S_VBP: begin
        if (hs_trail) begin
          if (line_q == LINE_LAST) begin
            state_d = S_HBP;
            pix_d   = PW'(1);
          end else begin
            line_d = line_q + 1'b1;
          end
        end
      end
      S_HBP: begin
        if (p_tick) begin
          if (hs_lead || vs_lead) begin
            err_d   = 1'b1;
            state_d = S_ARM;
          end else if (pix_q == PIX_LAST) begin
            take_px = 1'b1;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (p_tick) begin
          if (hs_lead || vs_lead) begin
            err_d   = 1'b1;
            state_d = S_ARM;
          end else begin
            take_px = 1'b1;
          end
        end
      end
      S_HWAIT: begin
        if (vs_lead) begin
          err_d   = 1'b1;
          state_d = S_ARM;
        end else if (hs_trail) begin
          state_d = S_HBP;
          pix_d   = PW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (take_px) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = rgb;
      addr_d    = addr_q + 1'b1;
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_HWAIT;
        end
      end else begin
        col_d   = col_q + 1'b1;
        state_d = S_ACTIVE;
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - randomized bench for vga_capture against a position-based frame model
module tb_vga_capture;

  localparam int HA = 16, HBP = 4, HF = 3, HS = 5;
  localparam int HT = HA + HF + HS + HBP;
  localparam int VA = 6, VBP = 3, VF = 2, VS = 2;
  localparam int VT = VA + VF + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int AW = 7;
  localparam bit POL = 1'b0;

  logic          clk_100MHz = 1'b0;
  logic          reset_n = 1'b0;
  logic          p_tick = 1'b0;
  logic          hsync = ~POL;
  logic          vsync = ~POL;
  logic [11:0]   rgb = '0;
  logic          start = 1'b0;
  logic          busy, wr_en, frame_done, sync_err;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;

  vga_capture #(
    .H_ACTIVE(HA), .H_BP(HBP), .V_ACTIVE(VA), .V_BP(VBP), .SYNC_POL(POL), .ADDR_W(AW)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .p_tick(p_tick), .hsync(hsync),
    .vsync(vsync), .rgb(rgb), .start(start), .busy(busy), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // generator position and per-sample annotations
  int  gen_h = 0, gen_v = VA + VF;
  int  cur_h = 0, cur_v = 0;
  bit  glead = 1'b0;
  bit  glitch_en = 1'b0;
  int  glitch_row = 0, glitch_col = 0;
  bit  rand_mode = 1'b0;
  bit  start_req = 1'b0, poke_done = 1'b0, stray = 1'b0;

  // behavioural model: expected outputs for the next cycle
  bit            m_busy = 0, m_err = 0, m_armed = 0, m_cap = 0, m_done_pend = 0;
  bit            e_wr_en = 0, e_done = 0;
  logic [AW-1:0] e_addr = '0;
  logic [11:0]   e_data = '0;
  logic          m_vs_prev = ~POL;
  int            m_accepts = 0;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;
  logic [AW+11:0] wlog[$];
  int  n_done = 0, n_consec = 0;
  bit  prev_wr = 1'b0;

  // A captured frame is whatever active pixels follow an armed vsync trailing edge.
  always @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_err = 0; m_armed = 0; m_cap = 0; m_done_pend = 0;
      e_wr_en = 0; e_done = 0; e_addr = '0; e_data = '0; m_vs_prev = ~POL;
    end else begin
      e_wr_en = 0;
      e_done  = 0;
      if (m_done_pend) begin
        m_done_pend = 0; e_done = 1; m_busy = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_err = 0; m_armed = 1; m_accepts++;
        end
      end else if (p_tick) begin
        if (m_armed) begin
          if (m_vs_prev == POL && vsync != POL) begin
            m_armed = 0; m_cap = 1;
          end
        end else if (m_cap && cur_h < HA && cur_v < VA) begin
          if (glead) begin
            m_err = 1; m_cap = 0; m_armed = 1;
          end else begin
            e_wr_en = 1;
            e_addr  = AW'(cur_v * HA + cur_h);
            e_data  = rgb;
            if (cur_v == VA - 1 && cur_h == HA - 1) begin
              m_cap = 0; m_done_pend = 1;
            end
          end
        end
      end
      if (p_tick) m_vs_prev = vsync;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic compare_cycle();
    logic [AW+15:0] act, exp;
    act = {busy, wr_en, frame_done, sync_err, wr_en ? wr_addr : AW'(0), wr_en ? wr_data : 12'h0};
    exp = {m_busy, e_wr_en, e_done, m_err, e_wr_en ? e_addr : AW'(0), e_wr_en ? e_data : 12'h0};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cycle t=%0t act{busy,wr_en,done,err,addr,data}=%h exp=%h", $time, act, exp);
    end
    if (wr_en) wlog.push_back({wr_addr, wr_data});
    if (wr_en && prev_wr) n_consec++;
    prev_wr = wr_en;
    if (frame_done) n_done++;
  endtask

  task automatic cycle(input bit pt);
    p_tick = pt;
    start  = start_req || (poke_done && m_done_pend) ||
             (stray && m_busy && ($urandom_range(0, 15) == 0));
    start_req = 1'b0;
    @(negedge clk_100MHz);
    if (chk_en) compare_cycle();
  endtask

  task automatic tick();
    bit hs_on, vs_on;
    int gap;
    gap = $urandom_range(1, 3);
    for (int i = 0; i < gap; i++) cycle(1'b0);
    hs_on = (gen_h >= HA + HF) && (gen_h < HA + HF + HS);
    vs_on = (gen_v >= VA + VF) && (gen_v < VA + VF + VS);
    glead = 1'b0;
    if (glitch_en && gen_v == glitch_row && gen_h == glitch_col) begin
      hs_on = 1'b1; glead = 1'b1;
    end else if (glitch_en && gen_v == glitch_row && gen_h == glitch_col + 1) begin
      hs_on = 1'b1; glitch_en = 1'b0;
    end
    hsync = hs_on ? POL : ~POL;
    vsync = vs_on ? POL : ~POL;
    if (gen_h < HA && gen_v < VA) rgb = rand_mode ? 12'($urandom) : {gen_v[3:0], gen_h[7:0]};
    else                          rgb = rand_mode ? 12'($urandom) : 12'h000;
    cur_h = gen_h;
    cur_v = gen_v;
    cycle(1'b1);
    gen_h++;
    if (gen_h == HT) begin
      gen_h = 0;
      gen_v = (gen_v == VT - 1) ? 0 : gen_v + 1;
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int v, input int h);
    int k;
    k = 0;
    while (!(gen_v == v && gen_h == h) && k < FRAME) begin
      tick();
      k++;
    end
  endtask

  task automatic pulse_start();
    start_req = 1'b1;
    cycle(1'b0);
  endtask

  function automatic int log_at(input int idx);
    if (idx < 0 || idx >= wlog.size()) return -1;
    return int'(wlog[idx]);
  endfunction

  initial begin
    int mark, d0, acc0;

    cycle(1'b0);
    chk_en = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    check("reset_outputs", int'({busy, wr_en, frame_done, sync_err, wr_addr, wr_data}), 0);
    reset_n = 1'b1;
    cycle(1'b0);

    // full frame with the {row,col} pattern
    mark = wlog.size(); d0 = n_done;
    pulse_start();
    check("t1_busy_after_start", int'(busy), 1);
    run_ticks(2 * FRAME + 8);
    check("t1_write_count", wlog.size() - mark, HA * VA);
    check("t1_first_write", log_at(mark), int'({7'd0, 12'h000}));
    check("t1_last_write", log_at(wlog.size() - 1), int'({7'd95, 12'h50F}));
    check("t1_frame_done", n_done - d0, 1);
    check("t1_sync_err", int'(sync_err), 0);
    check("t1_idle", int'(busy), 0);

    // arm mid-frame: nothing until the next vsync trailing edge
    run_to(3, 5);
    pulse_start();
    mark = wlog.size();
    run_to(VA + VF + VS, 0);
    check("t2_no_early_write", wlog.size() - mark, 0);
    run_ticks(FRAME + 4);
    check("t2_first_write", log_at(mark), int'({7'd0, 12'h000}));
    check("t2_write_count", wlog.size() - mark, HA * VA);

    // early hsync in row 3 at column HA/2
    run_to(VA + VF, 0);
    mark = wlog.size(); d0 = n_done;
    glitch_row = 3; glitch_col = HA / 2; glitch_en = 1'b1;
    pulse_start();
    run_to(4, 0);
    cycle(1'b0);
    check("t3_err_set", int'(sync_err), 1);
    check("t3_busy_held", int'(busy), 1);
    check("t3_partial_count", wlog.size() - mark, 3 * HA + HA / 2);
    run_ticks(2 * FRAME);
    check("t3_total_count", wlog.size() - mark, 3 * HA + HA / 2 + HA * VA);
    check("t3_last_write", log_at(wlog.size() - 1), int'({7'd95, 12'h50F}));
    check("t3_frame_done", n_done - d0, 1);
    check("t3_err_sticky", int'(sync_err), 1);
    pulse_start();
    check("t3_err_cleared", int'(sync_err), 0);

    // reset in the middle of row 3
    mark = wlog.size(); d0 = n_done;
    run_to(3, 5);
    check("t5_pre_reset_count", wlog.size() - mark, 3 * HA + 5);
    reset_n = 1'b0;
    #1;
    check("t5_reset_outputs", int'({busy, wr_en, frame_done, sync_err, wr_addr, wr_data}), 0);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b0);
    reset_n = 1'b1;
    mark = wlog.size();
    run_ticks(2 * FRAME);
    check("t5_no_writes", wlog.size() - mark, 0);
    check("t5_no_done", n_done - d0, 0);
    check("t5_idle", int'(busy), 0);

    // randomized captures with stray starts while busy and in the DONE cycle
    for (int it = 0; it < 6; it++) begin
      rand_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        glitch_row = $urandom_range(0, VA - 1);
        glitch_col = $urandom_range(0, HA - 1);
        glitch_en  = 1'b1;
      end
      run_ticks($urandom_range(0, FRAME - 1));
      d0 = n_done; acc0 = m_accepts;
      pulse_start();
      poke_done = 1'b1;
      stray     = 1'b1;
      run_ticks(4 * FRAME);
      poke_done = 1'b0;
      stray     = 1'b0;
      glitch_en = 1'b0;
      check("t6_one_frame_per_start", n_done - d0, 1);
      check("t6_idle", int'(busy), 0);
    end

    check("t4_no_back_to_back_writes", n_consec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
